cmd_bus_master: RTL and testbench

Bus initiator for the command processing system. It accepts one command at a time on a valid/ready input, then drives the `EX_REQ`/`EX_ACK` slave bus used by the system's memories and peripherals. Bus fields are `ADDR`, `CMD`, `D_WR` and `D_RD`. One response beat (read data plus error flag) is returned per command. It sits between the command decoder and the bus slaves, and it is the master-side counterpart of every `S_*` slave port.

---
 rtl/cmd_bus_master_if.sv | 42 ++++
 rtl/cmd_bus_master.sv | 131 +++++++++++++
 tb/tb_cmd_bus_master.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_bus_master_if.sv
// Command-in / bus / response-out signal bundle for cmd_bus_master.
// master is the view of cmd_bus_master itself; slave is the view of its surroundings.
interface cmd_bus_master_if #(
  parameter int AW = 5
);
  logic          IN_VALID;
  logic          IN_READY;
  logic [2:0]    IN_CMD;
  logic [AW-1:0] IN_ADDR;
  logic [7:0]    IN_DATA;
  logic [AW-1:0] IN_LEN;

  logic          M_EX_REQ;
  logic [AW-1:0] M_ADDR;
  logic [2:0]    M_CMD;
  logic [7:0]    M_D_WR;
  logic          M_EX_ACK;
  logic [7:0]    M_D_RD;

  logic          OUT_VALID;
  logic          OUT_READY;
  logic [7:0]    OUT_DATA;
  logic          OUT_ERR;

  modport master (
    input  IN_VALID, IN_CMD, IN_ADDR, IN_DATA, IN_LEN,
    output IN_READY,
    output M_EX_REQ, M_ADDR, M_CMD, M_D_WR,
    input  M_EX_ACK, M_D_RD,
    output OUT_VALID, OUT_DATA, OUT_ERR,
    input  OUT_READY
  );

  modport slave (
    output IN_VALID, IN_CMD, IN_ADDR, IN_DATA, IN_LEN,
    input  IN_READY,
    input  M_EX_REQ, M_ADDR, M_CMD, M_D_WR,
    output M_EX_ACK, M_D_RD,
    input  OUT_VALID, OUT_DATA, OUT_ERR,
    output OUT_READY
  );
endinterface

// File: rtl/cmd_bus_master.sv
// Single-command bus initiator: takes one command, runs its EX_REQ/EX_ACK beats
// (with FILL bursts and a request timeout), then returns exactly one response beat.
module cmd_bus_master #(
  parameter int AW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  cmd_bus_master_if.master  bus
);

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [2:0] CMD_FILL  = 3'd3;
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state;
  logic [AW-1:0] beat_cnt;
  logic [7:0]    to_cnt;

  logic          req_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    cmd_q;
  logic [7:0]    dwr_q;
  logic          out_valid_q;
  logic [7:0]    out_data_q;
  logic          out_err_q;

  // IN_READY is decoded from state so it drops in the same cycle reset is asserted.
  assign bus.IN_READY  = (state == IDLE) & ~RST;
  assign bus.M_EX_REQ  = req_q;
  assign bus.M_ADDR    = addr_q;
  assign bus.M_CMD     = cmd_q;
  assign bus.M_D_WR    = dwr_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_ERR   = out_err_q;

  // NOTE: all state updates use non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      to_cnt      <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      cmd_q       <= 3'd0;
      dwr_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.IN_VALID) begin
            out_data_q <= 8'd0;
            out_err_q  <= 1'b0;
            to_cnt     <= '0;
            case (bus.IN_CMD)
              CMD_NOP: begin
                out_valid_q <= 1'b1;
                state       <= RESP;
              end
              CMD_WRITE, CMD_FILL: begin
                cmd_q    <= CMD_WRITE;
                addr_q   <= bus.IN_ADDR;
                dwr_q    <= bus.IN_DATA;
                req_q    <= 1'b1;
                beat_cnt <= (bus.IN_CMD == CMD_FILL) ? bus.IN_LEN : '0;
                state    <= REQ;
              end
              CMD_READ: begin
                cmd_q    <= CMD_READ;
                addr_q   <= bus.IN_ADDR;
                req_q    <= 1'b1;
                beat_cnt <= '0;
                state    <= REQ;
              end
              default: begin
                out_err_q   <= 1'b1;
                out_valid_q <= 1'b1;
                state       <= RESP;
              end
            endcase
          end
        end

        REQ: begin
          if (bus.M_EX_ACK) begin
            to_cnt <= '0;
            if (cmd_q == CMD_READ) out_data_q <= bus.M_D_RD;
            if (beat_cnt != '0) begin
              beat_cnt <= beat_cnt - 1'b1;
              addr_q   <= addr_q + 1'b1;
            end else begin
              req_q       <= 1'b0;
              cmd_q       <= 3'd0;
              out_valid_q <= 1'b1;
              state       <= RESP;
            end
          end else if (to_cnt == TO_LAST) begin
            // Abort drops any remaining FILL beats; completed beats stay written.
            req_q       <= 1'b0;
            cmd_q       <= 3'd0;
            out_data_q  <= 8'd0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            to_cnt      <= '0;
            state       <= RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end

        RESP: begin
          if (bus.OUT_READY) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_bus_master.sv
// Directed bench for cmd_bus_master: a memory-backed bus slave with selectable
// ack behaviour, and a response scoreboard filled as commands are issued.
module tb_cmd_bus_master;

  localparam int AW = 5;

  logic CLK;
  logic RST;

  cmd_bus_master_if #(.AW(AW)) bus ();

  cmd_bus_master #(.AW(AW), .TIMEOUT(15)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } resp_t;

  resp_t      exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         ack_mode = 0;   // 0: ack tied high, 1: two wait cycles per beat, 2: never ack
  int         w = 0;
  int         wr_count = 0;
  int         overlap = 0;
  logic [4:0] last_wr_addr;
  logic [7:0] last_wr_data;
  logic [7:0] mem [32];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bus slave memory; contents start as mem[i] = i.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
    end else if (!RST && bus.M_EX_REQ && bus.M_EX_ACK && bus.M_CMD == 3'd1) begin
      mem[bus.M_ADDR] <= bus.M_D_WR;
      wr_count        <= wr_count + 1;
      last_wr_addr    <= bus.M_ADDR;
      last_wr_data    <= bus.M_D_WR;
    end
  end

  // Ack / read-data generation, driven away from the active edge.
  always @(negedge CLK) begin
    logic a;
    a = 1'b0;
    if (ack_mode == 0) begin
      a = 1'b1;
      w <= 0;
    end else if (ack_mode == 1) begin
      if (!bus.M_EX_REQ) begin
        w <= 0;
      end else if (w == 2) begin
        a = 1'b1;
        w <= 0;
      end else begin
        w <= w + 1;
      end
    end
    bus.M_EX_ACK <= a;
    bus.M_D_RD   <= (ack_mode == 2) ? 8'h5A : (a ? mem[bus.M_ADDR] : 8'hEE);
    if (bus.IN_READY && bus.OUT_VALID) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Present a command at a negedge, wait for acceptance, return at the negedge after accept.
  task automatic issue(input string tag, input logic [2:0] cmd, input logic [4:0] addr,
                       input logic [7:0] data, input logic [4:0] len,
                       input logic [7:0] exp_data, input logic exp_err, input bit push);
    bit ok;
    ok = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.IN_CMD   = cmd;
    bus.IN_ADDR  = addr;
    bus.IN_DATA  = data;
    bus.IN_LEN   = len;
    for (int i = 0; i < 100; i++) begin
      if (bus.IN_READY) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check({tag, "_accept"}, ok, 1'b1);
    if (!ok) begin
      bus.IN_VALID = 1'b0;
      return;
    end
    if (push) exp_q.push_back('{data: exp_data, err: exp_err});
    @(posedge CLK);
    #1 acc_cyc = cyc;
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
  endtask

  // Wait for OUT_VALID, counting request cycles, and score the response.
  task automatic await_resp(input string tag, input bit chk_addr, input logic [4:0] exp_addr,
                            output int req_cycles, output int lat);
    bit    seen;
    int    addr_bad;
    resp_t r;
    seen       = 1'b0;
    addr_bad   = 0;
    req_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.OUT_VALID) begin
        seen = 1'b1;
        break;
      end
      if (bus.M_EX_REQ) begin
        req_cycles++;
        if (chk_addr && bus.M_ADDR !== exp_addr) addr_bad++;
      end
      @(negedge CLK);
    end
    lat = cyc - acc_cyc;
    check({tag, "_resp_seen"}, seen, 1'b1);
    if (chk_addr) check({tag, "_addr_stable"}, addr_bad, 0);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_nonempty"}, 0, 1);
    end else begin
      r = exp_q.pop_front();
      check({tag, "_data"}, bus.OUT_DATA, r.data);
      check({tag, "_err"}, bus.OUT_ERR, r.err);
    end
  endtask

  // Complete the response handshake and confirm the master is idle again.
  task automatic handshake(input string tag);
    bus.OUT_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check({tag, "_out_valid_low"}, bus.OUT_VALID, 1'b0);
    check({tag, "_in_ready_high"}, bus.IN_READY, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    int lat;
    int wc;
    int ov_seen;

    RST           = 1'b1;
    bus.IN_VALID  = 1'b0;
    bus.IN_CMD    = 3'd0;
    bus.IN_ADDR   = '0;
    bus.IN_DATA   = 8'd0;
    bus.IN_LEN    = '0;
    bus.OUT_READY = 1'b1;
    ack_mode      = 0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_req", bus.M_EX_REQ, 1'b0);
    check("rst_cmd", bus.M_CMD, 3'd0);
    check("rst_addr", bus.M_ADDR, 5'd0);
    check("rst_dwr", bus.M_D_WR, 8'd0);
    check("rst_out_valid", bus.OUT_VALID, 1'b0);
    check("rst_out_data", bus.OUT_DATA, 8'd0);
    check("rst_out_err", bus.OUT_ERR, 1'b0);
    check("rst_in_ready_during", bus.IN_READY, 1'b0);
    RST = 1'b0;
    #1 check("rst_in_ready_after", bus.IN_READY, 1'b1);
    @(negedge CLK);

    // Single write then read back, zero-wait slave
    wc = wr_count;
    issue("wr5", 3'd1, 5'd5, 8'hA5, 5'd0, 8'h00, 1'b0, 1'b1);
    check("wr5_req", bus.M_EX_REQ, 1'b1);
    check("wr5_cmd", bus.M_CMD, 3'd1);
    check("wr5_addr", bus.M_ADDR, 5'd5);
    check("wr5_dwr", bus.M_D_WR, 8'hA5);
    await_resp("wr5", 1'b1, 5'd5, req_cycles, lat);
    check("wr5_req_cycles", req_cycles, 1);
    check("wr5_resp_latency", lat, 1);
    check("wr5_resp_cmd_idle", bus.M_CMD, 3'd0);
    handshake("wr5");
    check("wr5_total_cycles", cyc - acc_cyc, 2);
    check("wr5_beats", wr_count - wc, 1);
    check("wr5_beat_addr", last_wr_addr, 5'd5);
    check("wr5_beat_data", last_wr_data, 8'hA5);

    issue("rd5", 3'd2, 5'd5, 8'h00, 5'd0, 8'hA5, 1'b0, 1'b1);
    check("rd5_cmd", bus.M_CMD, 3'd2);
    await_resp("rd5", 1'b1, 5'd5, req_cycles, lat);
    check("rd5_resp_latency", lat, 1);
    handshake("rd5");
    check("rd5_total_cycles", cyc - acc_cyc, 2);

    // FILL with address wrap
    wc = wr_count;
    issue("fill", 3'd3, 5'd30, 8'h3C, 5'd3, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [4:0] ea;
      ea = 5'd30 + 5'(i);
      check($sformatf("fill_req_%0d", i), bus.M_EX_REQ, 1'b1);
      check($sformatf("fill_addr_%0d", i), bus.M_ADDR, ea);
      if (i < 3) @(negedge CLK);
    end
    await_resp("fill", 1'b0, 5'd0, req_cycles, lat);
    check("fill_latency", lat, 4);
    handshake("fill");
    check("fill_beats", wr_count - wc, 4);
    issue("rd30", 3'd2, 5'd30, 8'h00, 5'd0, 8'h3C, 1'b0, 1'b1);
    await_resp("rd30", 1'b1, 5'd30, req_cycles, lat);
    handshake("rd30");
    issue("rd31", 3'd2, 5'd31, 8'h00, 5'd0, 8'h3C, 1'b0, 1'b1);
    await_resp("rd31", 1'b1, 5'd31, req_cycles, lat);
    handshake("rd31");
    issue("rd0", 3'd2, 5'd0, 8'h00, 5'd0, 8'h3C, 1'b0, 1'b1);
    await_resp("rd0", 1'b1, 5'd0, req_cycles, lat);
    handshake("rd0");
    issue("rd1", 3'd2, 5'd1, 8'h00, 5'd0, 8'h3C, 1'b0, 1'b1);
    await_resp("rd1", 1'b1, 5'd1, req_cycles, lat);
    handshake("rd1");
    issue("rd2", 3'd2, 5'd2, 8'h00, 5'd0, 8'h02, 1'b0, 1'b1);
    await_resp("rd2", 1'b1, 5'd2, req_cycles, lat);
    handshake("rd2");

    // Wait states: two ack-low cycles per beat; D_RD is junk except at the ack edge
    ack_mode = 1;
    issue("wait_rd", 3'd2, 5'd5, 8'h00, 5'd0, 8'hA5, 1'b0, 1'b1);
    await_resp("wait_rd", 1'b1, 5'd5, req_cycles, lat);
    check("wait_rd_req_cycles", req_cycles, 3);
    handshake("wait_rd");

    // Timeout: ack never arrives
    ack_mode = 2;
    issue("tmo", 3'd2, 5'd7, 8'h00, 5'd0, 8'h00, 1'b1, 1'b1);
    await_resp("tmo", 1'b1, 5'd7, req_cycles, lat);
    check("tmo_req_cycles", req_cycles, 15);
    check("tmo_req_low", bus.M_EX_REQ, 1'b0);
    check("tmo_cmd_idle", bus.M_CMD, 3'd0);
    handshake("tmo");
    ack_mode = 0;

    // NOP and illegal command: response without bus activity
    issue("nop", 3'd0, 5'd9, 8'h11, 5'd0, 8'h00, 1'b0, 1'b1);
    await_resp("nop", 1'b0, 5'd0, req_cycles, lat);
    check("nop_no_req", req_cycles, 0);
    handshake("nop");
    issue("ill", 3'd6, 5'd9, 8'h11, 5'd0, 8'h00, 1'b1, 1'b1);
    await_resp("ill", 1'b0, 5'd0, req_cycles, lat);
    check("ill_no_req", req_cycles, 0);
    handshake("ill");

    // Backpressure: response held for 5 cycles
    bus.OUT_READY = 1'b0;
    issue("bp", 3'd2, 5'd5, 8'h00, 5'd0, 8'hA5, 1'b0, 1'b1);
    await_resp("bp", 1'b1, 5'd5, req_cycles, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check($sformatf("bp_valid_%0d", i), bus.OUT_VALID, 1'b1);
      check($sformatf("bp_data_%0d", i), bus.OUT_DATA, 8'hA5);
      check($sformatf("bp_in_ready_%0d", i), bus.IN_READY, 1'b0);
    end
    handshake("bp");

    // Reset during beat 2 of an 8-beat FILL at address 10
    issue("rfill", 3'd3, 5'd10, 8'h77, 5'd7, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    check("rfill_beat2_addr", bus.M_ADDR, 5'd11);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("rfill_req", bus.M_EX_REQ, 1'b0);
    check("rfill_cmd", bus.M_CMD, 3'd0);
    check("rfill_out_valid", bus.OUT_VALID, 1'b0);
    RST = 1'b0;
    #1 check("rfill_in_ready", bus.IN_READY, 1'b1);
    wc      = wr_count;
    ov_seen = 0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.OUT_VALID || bus.M_EX_REQ) ov_seen++;
    end
    check("rfill_quiet", ov_seen, 0);
    check("rfill_no_more_writes", wr_count - wc, 0);
    check("rfill_mem10", mem[10], 8'h77);
    check("rfill_mem12", mem[12], 8'h0C);

    // Normal operation resumes after reset
    issue("rd10", 3'd2, 5'd10, 8'h00, 5'd0, 8'h77, 1'b0, 1'b1);
    await_resp("rd10", 1'b1, 5'd10, req_cycles, lat);
    handshake("rd10");

    check("scoreboard_drained", exp_q.size(), 0);
    check("ready_valid_never_both", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
